fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/kanade_pkg.sv | 17 +
 rtl/fetch_queue.sv | 79 +++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/kanade_pkg.sv
// rtl/kanade_pkg.sv - shared constants and fetch FSM state encoding
//
// Purpose: common datapath width, NOP encoding, PC increment and the
// fetch FSM state enumeration used by fetch_unit and fetch_queue.
package kanade_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INS_NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular instruction queue of {ins, next_pc} entries
//
// Purpose: buffers fetched instructions between instruction memory and the
// FD stage register. Head outputs read registered storage only.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_ins,
//   push_next_pc        write one entry at the tail
//   pop                 drop the head entry
//   flush               empty the queue (wins over push and pop)
//   count               number of valid entries
//   head_ins,
//   head_next_pc        head entry, zero when the queue is empty
module fetch_queue
  import kanade_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [XLEN-1:0]              push_ins,
  input  logic [XLEN-1:0]              push_next_pc,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [XLEN-1:0]              head_ins,
  output logic [XLEN-1:0]              head_next_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]  ins_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem  [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full queue is only accepted when a pop frees a slot.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) begin
      ins_mem[wr_ptr] <= push_ins;
      pc_mem[wr_ptr]  <= push_next_pc;
    end
  end

  always_comb begin
    head_ins     = INS_NOP;
    head_next_pc = '0;
    if (count != '0) begin
      head_ins     = ins_mem[rd_ptr];
      head_next_pc = pc_mem[rd_ptr];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with redirect handling
//
// Purpose: issues word fetches to instruction memory, queues returned
// instructions for the FD stage and handles taken-branch redirects,
// including dropping the response of a request in flight.
// Ports:
//   clk, reset                clock, synchronous active-high reset
//   imem_req, imem_addr       fetch request and its address (registered)
//   imem_ack, imem_rdata      request completion and returned instruction
//   out_valid, out_ready      FD handshake; pop on valid && ready
//   out_ins, out_next_pc      head instruction and its address plus 4
//   redirect, redirect_pc     new fetch address from EX/MEM
module fetch_unit
  import kanade_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_ins,
  output logic [XLEN-1:0] out_next_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  fetch_state_t     state;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  pc_plus;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W:0]   count_after;
  logic             push;
  logic             pop;

  assign pc_plus   = fetch_pc + PC_STEP;
  assign out_valid = (q_count != '0);
  assign push      = (state == WAIT) && imem_ack && !redirect;
  assign pop       = out_valid && out_ready;
  assign count_after = {1'b0, q_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_ins     (imem_rdata),
    .push_next_pc (pc_plus),
    .pop          (pop),
    .flush        (redirect),
    .count        (q_count),
    .head_ins     (out_ins),
    .head_next_pc (out_next_pc)
  );

  // imem_addr only moves when a new request starts; in DROP it keeps the
  // abandoned address while fetch_pc already holds the redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc  <= redirect_pc;
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= redirect_pc;
          end else if ({1'b0, q_count} < DEPTH_C) begin
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            if (imem_ack) begin
              imem_addr <= redirect_pc;
            end else begin
              state <= DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= pc_plus;
            // Only keep requesting if the next response has a guaranteed slot.
            if (count_after < DEPTH_C) begin
              imem_addr <= pc_plus;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (imem_ack) begin
            state     <= WAIT;
            imem_addr <= redirect ? redirect_pc : fetch_pc;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_next_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic        out_valid_w;
  logic [31:0] out_ins_w;
  logic [31:0] out_next_pc_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory model: each word reads back as its address xor K.
  assign imem_rdata   = imem_addr ^ K;
  assign imem_rdata_w = imem_addr_w ^ K;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ins     (out_ins),
    .out_next_pc (out_next_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_w (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req_w),
    .imem_addr   (imem_addr_w),
    .imem_ack    (1'b1),
    .imem_rdata  (imem_rdata_w),
    .out_valid   (out_valid_w),
    .out_ready   (1'b1),
    .out_ins     (out_ins_w),
    .out_next_pc (out_next_pc_w),
    .redirect    (1'b0),
    .redirect_pc (32'h0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    imem_ack    = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_req",   {31'b0, imem_req},  32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ins",   out_ins,            32'd0);
    chk("rst_npc",   out_next_pc,        32'd0);
    chk("rst_req_w", {31'b0, imem_req_w}, 32'd0);

    // Streaming: ack and ready tied high
    reset     = 1'b0;
    imem_ack  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("s0_req",    {31'b0, imem_req},  32'd1);
    chk("s0_addr",   imem_addr,          32'h0);
    chk("s0_valid",  {31'b0, out_valid}, 32'd0);
    chk("w0_addr",   imem_addr_w,        32'hFFFF_FFFC);
    tick();
    chk("s1_addr",   imem_addr,          32'h4);
    chk("s1_valid",  {31'b0, out_valid}, 32'd1);
    chk("s1_npc",    out_next_pc,        32'h4);
    chk("s1_ins",    out_ins,            32'hDEAD_0000);
    chk("w1_addr",   imem_addr_w,        32'h0);
    chk("w1_npc",    out_next_pc_w,      32'h0);
    chk("w1_ins",    out_ins_w,          32'h2152_FFFC);
    tick();
    chk("s2_addr",   imem_addr,          32'h8);
    chk("s2_npc",    out_next_pc,        32'h8);
    chk("s2_ins",    out_ins,            32'hDEAD_0004);
    tick();
    chk("s3_addr",   imem_addr,          32'hC);
    chk("s3_npc",    out_next_pc,        32'hC);

    // Back-pressure: queue fills, requests stop
    out_ready = 1'b0;
    tick();
    chk("bp0_req",   {31'b0, imem_req},  32'd0);
    chk("bp0_npc",   out_next_pc,        32'hC);
    for (int i = 0; i < 4; i++) tick();
    chk("bp4_req",   {31'b0, imem_req},  32'd0);
    chk("bp4_npc",   out_next_pc,        32'hC);
    chk("bp4_ins",   out_ins,            32'hDEAD_0008);
    out_ready = 1'b1;
    imem_ack  = 1'b0;
    tick();
    chk("dr0_npc",   out_next_pc,        32'h10);
    chk("dr0_ins",   out_ins,            32'hDEAD_000C);
    chk("dr0_req",   {31'b0, imem_req},  32'd0);
    tick();
    chk("dr1_valid", {31'b0, out_valid}, 32'd0);
    chk("dr1_req",   {31'b0, imem_req},  32'd1);
    chk("dr1_addr",  imem_addr,          32'h10);

    // Redirect with request pending, ack two cycles later
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    chk("rd0_req",   {31'b0, imem_req},  32'd1);
    chk("rd0_addr",  imem_addr,          32'h10);
    chk("rd0_valid", {31'b0, out_valid}, 32'd0);
    redirect = 1'b0;
    tick();
    chk("rd1_addr",  imem_addr,          32'h10);
    chk("rd1_valid", {31'b0, out_valid}, 32'd0);
    imem_ack = 1'b1;
    tick();
    chk("rd2_addr",  imem_addr,          32'h200);
    chk("rd2_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("rd3_valid", {31'b0, out_valid}, 32'd1);
    chk("rd3_npc",   out_next_pc,        32'h204);
    chk("rd3_ins",   out_ins,            32'hDEAD_0200);

    // Redirect and ack in the same cycle
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    tick();
    chk("ra0_addr",  imem_addr,          32'h20);
    chk("ra0_valid", {31'b0, out_valid}, 32'd0);
    redirect_pc = 32'h80;
    tick();
    chk("ra1_addr",  imem_addr,          32'h80);
    chk("ra1_valid", {31'b0, out_valid}, 32'd0);
    redirect = 1'b0;
    tick();
    chk("ra2_valid", {31'b0, out_valid}, 32'd1);
    chk("ra2_npc",   out_next_pc,        32'h84);
    chk("ra2_ins",   out_ins,            32'hDEAD_0080);

    // Reset while a dropped request is outstanding
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    chk("dp0_req",   {31'b0, imem_req},  32'd1);
    chk("dp0_addr",  imem_addr,          32'h84);
    redirect = 1'b0;
    reset    = 1'b1;
    tick();
    chk("rr_req",    {31'b0, imem_req},  32'd0);
    chk("rr_valid",  {31'b0, out_valid}, 32'd0);
    chk("rr_addr",   imem_addr,          32'h0);
    chk("rr_npc",    out_next_pc,        32'h0);
    reset    = 1'b0;
    imem_ack = 1'b1;
    tick();
    chk("rl_req",    {31'b0, imem_req},  32'd1);
    chk("rl_addr",   imem_addr,          32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
